// File: rtl/uart_tx_fifo_if.sv
// Write-side port of the UART transmitter: valid/ready enqueue handshake plus queue occupancy.
// The producer holds the master modport and the transmitter holds the slave modport.
interface uart_tx_fifo_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
);
   logic [DATA_BITS-1:0]        wr_data;
   logic                        wr_valid;
   logic                        wr_ready;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   modport master (output wr_data, wr_valid, input wr_ready, fifo_count);
   modport slave  (input wr_data, wr_valid, output wr_ready, fifo_count);
endinterface

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter fed by a power-of-two transmit FIFO.
// Each frame is sent as start, data bits (LSB first), optional parity, then stop bits.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_fifo_if.slave  wr,
   output logic           tx,
   output logic           busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam int BW = 4;
   localparam logic [TW-1:0] BIT_LAST = TW'(CLKS_PER_BIT - 1);
   localparam logic          PAR_ODD  = (PARITY == 1);

   if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
       (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("uart_tx_fifo: illegal parameter combination");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count;
   logic [DATA_BITS-1:0] head;

   state_t               state;
   logic [TW-1:0]        timer;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bit;

   logic push, pop, bit_end, last_stop;

   assign head          = mem[rd_ptr];
   assign wr.fifo_count = count;
   assign wr.wr_ready   = (count != CW'(FIFO_DEPTH));
   assign push          = wr.wr_valid && wr.wr_ready;
   assign bit_end       = (timer == '0);
   assign last_stop     = (state == S_STOP) && bit_end && (bit_cnt == BW'(STOP_BITS - 1));
   // Words leave the queue only on a frame boundary, never mid-frame.
   assign pop           = (count != '0) && ((state == S_IDLE) || last_stop);

   // NOTE: storage has no reset; stale contents are unreachable once the pointers are cleared.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr.wr_data;
   end

   // NOTE: non-blocking assignments keep every register updating from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         tx      <= 1'b1;
         busy    <= 1'b0;
         timer   <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
      end else begin
         // Parity is fixed when the word is popped so the shifter can destroy the data.
         if (pop) begin
            shreg   <= head;
            par_bit <= (^head) ^ PAR_ODD;
         end
         case (state)
            S_IDLE: begin
               tx   <= 1'b1;
               busy <= 1'b0;
               if (pop) begin
                  tx    <= 1'b0;
                  busy  <= 1'b1;
                  timer <= BIT_LAST;
                  state <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  tx      <= shreg[0];
                  shreg   <= shreg >> 1;
                  bit_cnt <= '0;
                  timer   <= BIT_LAST;
                  state   <= S_DATA;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  timer <= BIT_LAST;
                  if (bit_cnt == BW'(DATA_BITS - 1)) begin
                     bit_cnt <= '0;
                     if (PARITY != 0) begin
                        tx    <= par_bit;
                        state <= S_PAR;
                     end else begin
                        tx    <= 1'b1;
                        state <= S_STOP;
                     end
                  end else begin
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            S_PAR: begin
               if (bit_end) begin
                  tx    <= 1'b1;
                  timer <= BIT_LAST;
                  state <= S_STOP;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  timer <= BIT_LAST;
                  if (last_stop) begin
                     bit_cnt <= '0;
                     if (pop) begin
                        tx    <= 1'b0;
                        state <= S_START;
                     end else begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BW'(1);
                  end
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four configurations side by side (8N1, 8E1, 8O1, 5N2) at 4 clocks/bit.
// Expected line waveforms are hand-written bit strings, one character per bit time.
module tb_uart_tx_fifo;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_8n1 ();
   uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_even ();
   uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_odd ();
   uart_tx_fifo_if #(.DATA_BITS(5), .FIFO_DEPTH(16)) if_5n2 ();

   logic tx_8n1, tx_even, tx_odd, tx_5n2;
   logic busy_8n1, busy_even, busy_odd, busy_5n2;

   uart_tx_fifo #(.CLKS_PER_BIT(4)) u_8n1 (
      .clk(clk), .rst(rst), .wr(if_8n1.slave), .tx(tx_8n1), .busy(busy_8n1));
   uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY(2)) u_even (
      .clk(clk), .rst(rst), .wr(if_even.slave), .tx(tx_even), .busy(busy_even));
   uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY(1)) u_odd (
      .clk(clk), .rst(rst), .wr(if_odd.slave), .tx(tx_odd), .busy(busy_odd));
   uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(5), .STOP_BITS(2)) u_5n2 (
      .clk(clk), .rst(rst), .wr(if_5n2.slave), .tx(tx_5n2), .busy(busy_5n2));

   logic [3:0] tx_all, busy_all;
   assign tx_all   = {tx_5n2, tx_odd, tx_even, tx_8n1};
   assign busy_all = {busy_5n2, busy_odd, busy_even, busy_8n1};

   int n_compared   = 0;
   int n_mismatched = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One character per bit time, four clocks per bit; cycle i lands in bit i.
   function automatic logic [127:0] stretch(input string s);
      logic [127:0] v = '0;
      for (int i = 0; i < s.len(); i++)
         for (int j = 0; j < 4; j++)
            v[i*4+j] = (s[i] == "1");
      return v;
   endfunction

   logic [127:0] cap [4];
   int           bcnt [4];

   // Samples every instance on n consecutive negedges, starting with the current one.
   task automatic cap_run(input int n);
      for (int k = 0; k < 4; k++) begin
         cap[k]  = '0;
         bcnt[k] = 0;
      end
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 4; k++) begin
            cap[k][i] = tx_all[k];
            bcnt[k]  += int'(busy_all[k]);
         end
         @(negedge clk);
      end
   endtask

   logic [7:0] words [18] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99,
                              8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hF0, 8'h0F, 8'h5A, 8'hA5};
   logic [7:0] queued [4] = '{8'h80, 8'hC3, 8'h3C, 8'h99};
   logic [7:0] rx_bytes [18];
   int         rx_n;
   int         idx, edge_no, first_edge, last_edge;
   bit         acc, full_seen;
   logic [7:0] rx_byte;
   int         rx_t;

   initial begin
      rst = 1'b1;
      if_8n1.wr_valid  = 1'b0; if_8n1.wr_data  = '0;
      if_even.wr_valid = 1'b0; if_even.wr_data = '0;
      if_odd.wr_valid  = 1'b0; if_odd.wr_data  = '0;
      if_5n2.wr_valid  = 1'b0; if_5n2.wr_data  = '0;
      repeat (3) @(negedge clk);
      check("rst_tx", tx_all, 4'hF);
      check("rst_busy", busy_all, 4'h0);
      check("rst_count", if_8n1.fifo_count, 0);
      check("rst_ready", if_8n1.wr_ready, 1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single frames on all four configurations, written on the same edge E.
      if_8n1.wr_data = 8'h55;  if_8n1.wr_valid  = 1'b1;
      if_even.wr_data = 8'h07; if_even.wr_valid = 1'b1;
      if_odd.wr_data = 8'h07;  if_odd.wr_valid  = 1'b1;
      if_5n2.wr_data = 5'h1F;  if_5n2.wr_valid  = 1'b1;
      @(negedge clk);
      if_8n1.wr_valid = 1'b0; if_even.wr_valid = 1'b0;
      if_odd.wr_valid = 1'b0; if_5n2.wr_valid  = 1'b0;
      check("lat_count_e", if_8n1.fifo_count, 1);
      check("lat_tx_e", tx_8n1, 1);
      @(negedge clk);
      check("lat_count_e1", if_8n1.fifo_count, 0);
      check("lat_busy_e1", busy_8n1, 1);
      cap_run(48);
      check("8n1_line", cap[0], stretch("010101010111"));
      check("8n1_busy", bcnt[0], 40);
      check("even_line", cap[1], stretch("011100000111"));
      check("even_busy", bcnt[1], 44);
      check("odd_line", cap[2], stretch("011100000011"));
      check("odd_busy", bcnt[2], 44);
      check("5n2_line", cap[3], stretch("011111111111"));
      check("5n2_busy", bcnt[3], 32);

      // Back-to-back frames: 0xA1 at E, 0x3C at E+1, no idle gap.
      if_8n1.wr_data = 8'hA1; if_8n1.wr_valid = 1'b1;
      @(negedge clk);
      if_8n1.wr_data = 8'h3C;
      @(negedge clk);
      if_8n1.wr_valid = 1'b0;
      check("b2b_count", if_8n1.fifo_count, 1);
      cap_run(84);
      check("b2b_line", cap[0], stretch("010000101100011110011"));
      check("b2b_busy", bcnt[0], 80);
      repeat (4) @(negedge clk);

      // Burst of 18 words with wr_valid held, decoded by a mid-bit sampling receiver.
      idx = 0; edge_no = 0; first_edge = 0; last_edge = 0; full_seen = 1'b0; rx_n = 0; rx_t = 0;
      fork
         begin
            if_8n1.wr_data  = words[0];
            if_8n1.wr_valid = 1'b1;
            while (idx < 18 && edge_no < 200) begin
               acc = if_8n1.wr_ready;
               @(posedge clk);
               edge_no++;
               if (acc) begin
                  if (idx == 0)  first_edge = edge_no;
                  if (idx == 17) last_edge  = edge_no;
                  idx++;
               end
               @(negedge clk);
               if (!if_8n1.wr_ready && !full_seen) begin
                  full_seen = 1'b1;
                  check("burst_accepted_at_full", idx, 17);
                  check("burst_count_full", if_8n1.fifo_count, 16);
               end
               if (idx < 18) if_8n1.wr_data = words[idx];
               else          if_8n1.wr_valid = 1'b0;
            end
            if_8n1.wr_valid = 1'b0;
         end
         begin
            while (rx_n < 18 && rx_t < 1200) begin
               @(negedge clk); rx_t++;
               if (tx_8n1 === 1'b0) begin
                  repeat (2) @(negedge clk);
                  rx_t += 2;
                  for (int k = 0; k < 8; k++) begin
                     repeat (4) @(negedge clk);
                     rx_t += 4;
                     rx_byte[k] = tx_8n1;
                  end
                  repeat (4) @(negedge clk);
                  rx_t += 4;
                  rx_bytes[rx_n] = rx_byte;
                  rx_n++;
               end
            end
         end
      join
      check("burst_full_seen", full_seen, 1);
      check("burst_18th_edge", last_edge - first_edge, 42);
      check("rx_count", rx_n, 18);
      for (int i = 0; i < 18; i++)
         check($sformatf("rx_byte_%0d", i), rx_bytes[i], words[i]);
      repeat (8) @(negedge clk);

      // Reset mid-DATA of 0x80 with three more words queued.
      if_8n1.wr_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if_8n1.wr_data = queued[i];
         @(negedge clk);
      end
      if_8n1.wr_valid = 1'b0;
      check("rst_mid_queued", if_8n1.fifo_count, 3);
      repeat (8) @(negedge clk);
      check("rst_mid_busy_before", busy_8n1, 1);
      rst = 1'b1;
      #1;
      check("rst_mid_tx", tx_8n1, 1);
      check("rst_mid_busy", busy_8n1, 0);
      check("rst_mid_count", if_8n1.fifo_count, 0);
      check("rst_mid_ready", if_8n1.wr_ready, 1);
      @(negedge clk);
      rst = 1'b0;
      cap_run(60);
      check("post_rst_idle_line", cap[0], stretch("111111111111111"));
      check("post_rst_idle_busy", bcnt[0], 0);
      if_8n1.wr_data = 8'h12; if_8n1.wr_valid = 1'b1;
      @(negedge clk);
      if_8n1.wr_valid = 1'b0;
      @(negedge clk);
      cap_run(48);
      check("post_rst_line", cap[0], stretch("001001000111"));
      check("post_rst_busy", bcnt[0], 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO. It is the next-generation replacement for the fixed 8N1 transmitter that drives the board `tx` line from the `Top` memory-mapped UART port. It is also looped back to `rx` in the CPU echo-back simulation. It adds configurable data width, parity, stop bits and baud divisor, plus a valid/ready write port that buffers bursts from the core.

## Interface
- `CLKS_PER_BIT`, default 868 — clock cycles per serial bit (100 MHz / 115200); legal ≥ 2.
- `DATA_BITS`, default 8 — payload bits per frame; legal 5–9.
- `PARITY`, default 0 — parity mode: 0 none, 1 odd, 2 even.
- `STOP_BITS`, default 1 — stop bits per frame; legal 1 or 2.
- `FIFO_DEPTH`, default 16 — FIFO entries; power of two, ≥ 2.
- `clk` input 1 — system clock; all logic on rising edge.
- `rst` input 1 — reset. One clock; reset is asynchronous and active-high.
- `wr_data` input `DATA_BITS` — word to enqueue.
- `wr_valid` input 1 — write request.
- `wr_ready` output 1 — FIFO can accept a word (`fifo_count < FIFO_DEPTH`).
- `tx` output 1 — serial line, idle high. Registered output.
- `busy` output 1 — a frame is on the line. Registered output.
- `fifo_count` output `$clog2(FIFO_DEPTH)+1` — words queued, not yet started.

## Operation
- **Write.**
  - A write is accepted on a rising edge with `wr_valid && wr_ready`.
  - A write when full has no effect; producer must hold `wr_valid` until ready.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** `tx`=1, `busy`=0. If `fifo_count`≠0, pop the head into a shift register and go to START.
  - **START:** `tx`=0 for one bit time, then DATA.
  - **DATA:** shift out `DATA_BITS` bits, LSB first, one bit time each. Then PARITY if `PARITY`≠0, else STOP.
  - **PARITY:**
    - Odd mode: bit is chosen so data+parity has an odd count of ones.
    - Even mode: bit is chosen so the count is even.
  - **STOP:** `tx`=1 for `STOP_BITS` bit times. Then:
    - FIFO non-empty: pop and go directly to START. No idle bit between frames.
    - FIFO empty: go to IDLE.
- **Bit timer and counters.**
  - Bit timer reloads to `CLKS_PER_BIT-1` on every bit boundary and counts down to 0.
  - A bit counter tracks data and stop bits.
- **Frame length** = (1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS`) × `CLKS_PER_BIT` cycles, exactly.
- **FIFO.** Pointers wrap modulo `FIFO_DEPTH`. A push and a pop on the same edge leave `fifo_count` unchanged; both take effect.
- **Illegal parameters.** Values outside legal ranges trigger an elaboration-time `$error`.

## Timing
- **Reset values** (asynchronous, effective immediately, including mid-frame):
  - `tx`=1, `busy`=0, `fifo_count`=0, `wr_ready`=1.
  - FSM in IDLE; timer, counters and pointers cleared.
  - A partially sent frame is abandoned, not resumed.
- **Start latency.** A write accepted at edge E with the FSM idle and the FIFO empty:
  - `fifo_count`=1 after E.
  - At edge E+1 the word is popped: `fifo_count`=0, `tx`=0, `busy`=1.
- **Bit boundaries.** Every bit, including the first start bit, holds `tx` for exactly `CLKS_PER_BIT` cycles.
  - `tx` changes only on bit boundaries, so it is glitch-free.
- **`busy`:** high from the first start-bit cycle through the last stop-bit cycle. Falls on the edge that returns to IDLE.
  - Stays high across back-to-back frames.
- **`wr_ready`:** combinational from `fifo_count`. Goes low the cycle after the write that fills the FIFO.
  - Goes high again the cycle after a pop.
- **Pop timing:** only at IDLE→START or STOP→START transitions. Never mid-frame.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=16 unless stated.
1. 8N1, write 0x55 at edge E.
   - `tx`=0 for cycles E+1..E+4.
   - Then 1,0,1,0,1,0,1,0, 4 cycles each.
   - Then stop 1 for 4 cycles.
   - `busy` high exactly 40 cycles; `fifo_count` returns to 0 at E+1.
2. Parity, data 0x07 (three ones).
   - `PARITY`=2 → parity bit 1; `PARITY`=1 → parity bit 0.
   - Frame is 44 cycles in both cases.
3. `STOP_BITS`=2, `DATA_BITS`=5, write 0x1F.
   - Start 0, five 1s, stop high 8 cycles.
   - `busy` for 32 cycles; bits 5–7 of `wr_data` ignored.
4. Write 0xA1 then 0x3C on consecutive edges.
   - Second start bit begins on the cycle immediately after the first frame's last stop cycle.
   - `busy` never drops; total 80 busy cycles.
5. Hold `wr_valid`=1 with 18 distinct words.
   - 17 accepted before `wr_ready` falls (one popped at E+1).
   - 18th accepted the cycle after the second pop.
   - All 18 appear on `tx` in order.
   - `tx` looped to a reference receiver model decodes identical bytes.
6. Assert `rst` for 1 cycle mid-DATA of 0x80 with 3 words queued.
   - `tx`=1, `busy`=0, `fifo_count`=0 immediately.
   - Line stays idle afterwards; a new write 0x12 is sent cleanly.
